// File: rtl/cpu_pkg.sv
// Shared encodings, pipeline register layouts and ALU helpers for the cpu core.
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        a_pc;
    logic        b_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  funct3;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] load_data;
  } mem_wb_t;

  // alt selects SUB/SRA; callers only raise it where the encoding permits.
  function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $signed(a) >>> b[4:0];
      ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'b0, a < b};
      ALU_PASSB: r = b;
      default:   r = a + b;
    endcase
    return r;
  endfunction

  function automatic fwd_sel_e fwd_pick(logic [4:0] rs, logic em_we, logic [4:0] em_rd,
                                        logic mw_we, logic [4:0] mw_rd);
    fwd_sel_e s;
    s = FWD_REG;
    if (rs != 5'd0 && mw_we && mw_rd == rs) s = FWD_WB;
    if (rs != 5'd0 && em_we && em_rd == rs) s = FWD_MEM;
    return s;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 GPR file: two async read ports with write-through, one posedge write port.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && wa != 5'd0) begin
      registers[wa] <= wd;
    end
  end

  // x0 is never written, so it always reads back zero.
  always_comb begin
    rd1 = registers[ra1];
    rd2 = registers[ra2];
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/cpu.sv
// 5-stage RV32I-subset pipeline: forwarding into EX, 1-cycle load-use stall,
// branches/jumps resolved in EX with a 2-slot flush.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instruction,
  output logic [31:0] data_addr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        mem_write,
  output logic        mem_read
);

  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex, id_dec;
  ex_mem_t     ex_mem, ex_res;
  mem_wb_t     mem_wb;

  logic        stall, flush, br_taken;
  logic [31:0] target, wb_val, rf_rd1, rf_rd2;
  logic [31:0] fa, fb, alu_a, alu_b;
  fwd_sel_e    sel_a, sel_b;

  assign instr_addr = pc;
  assign data_addr  = ex_mem.result;
  assign data_out   = ex_mem.store_data;
  assign mem_write  = ex_mem.mem_write;
  assign mem_read   = ex_mem.mem_read;
  assign wb_val     = mem_wb.mem_read ? mem_wb.load_data : mem_wb.result;

  cpu_regfile registers (
    .clk (clk),
    .rst (rst),
    .ra1 (if_id.instr[19:15]),
    .ra2 (if_id.instr[24:20]),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (mem_wb.reg_write),
    .wa  (mem_wb.rd),
    .wd  (wb_val)
  );

  // ID: decode; invalid slots and unknown opcodes leave every control bit low.
  logic [31:0] ins, imm_i, imm_s, imm_b, imm_u, imm_j;
  assign ins   = if_id.instr;
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    id_dec         = '0;
    id_dec.vld     = if_id.vld;
    id_dec.pc      = if_id.pc;
    id_dec.rs1_val = rf_rd1;
    id_dec.rs2_val = rf_rd2;
    id_dec.rs1     = ins[19:15];
    id_dec.rs2     = ins[24:20];
    id_dec.rd      = ins[11:7];
    id_dec.funct3  = ins[14:12];
    id_dec.alu_op  = ALU_ADD;
    if (if_id.vld) begin
      case (ins[6:0])
        OPC_OP: begin
          id_dec.reg_write = 1'b1;
          id_dec.alu_op    = alu_decode(ins[14:12], ins[30]);
        end
        OPC_OP_IMM: begin
          id_dec.reg_write = 1'b1;
          id_dec.b_imm     = 1'b1;
          id_dec.imm       = imm_i;
          id_dec.alu_op    = alu_decode(ins[14:12], ins[30] && ins[14:12] == F3_SR);
        end
        OPC_LOAD: begin
          id_dec.reg_write = 1'b1;
          id_dec.mem_read  = 1'b1;
          id_dec.b_imm     = 1'b1;
          id_dec.imm       = imm_i;
        end
        OPC_STORE: begin
          id_dec.mem_write = 1'b1;
          id_dec.b_imm     = 1'b1;
          id_dec.imm       = imm_s;
        end
        OPC_BRANCH: begin
          id_dec.branch = 1'b1;
          id_dec.imm    = imm_b;
        end
        OPC_JAL: begin
          id_dec.jal       = 1'b1;
          id_dec.reg_write = 1'b1;
          id_dec.imm       = imm_j;
        end
        OPC_JALR: begin
          id_dec.jalr      = 1'b1;
          id_dec.reg_write = 1'b1;
          id_dec.imm       = imm_i;
        end
        OPC_LUI: begin
          id_dec.reg_write = 1'b1;
          id_dec.b_imm     = 1'b1;
          id_dec.imm       = imm_u;
          id_dec.alu_op    = ALU_PASSB;
        end
        OPC_AUIPC: begin
          id_dec.reg_write = 1'b1;
          id_dec.b_imm     = 1'b1;
          id_dec.a_pc      = 1'b1;
          id_dec.imm       = imm_u;
        end
        default: ;
      endcase
    end
  end

  assign stall = if_id.vld && id_ex.mem_read && id_ex.rd != 5'd0 &&
                 (id_ex.rd == ins[19:15] || id_ex.rd == ins[24:20]);

  // EX: operand forwarding, ALU, branch resolution.
  always_comb begin
    sel_a = fwd_pick(id_ex.rs1, ex_mem.reg_write, ex_mem.rd, mem_wb.reg_write, mem_wb.rd);
    sel_b = fwd_pick(id_ex.rs2, ex_mem.reg_write, ex_mem.rd, mem_wb.reg_write, mem_wb.rd);
    case (sel_a)
      FWD_MEM: fa = ex_mem.result;
      FWD_WB:  fa = wb_val;
      default: fa = id_ex.rs1_val;
    endcase
    case (sel_b)
      FWD_MEM: fb = ex_mem.result;
      FWD_WB:  fb = wb_val;
      default: fb = id_ex.rs2_val;
    endcase
    alu_a = id_ex.a_pc  ? id_ex.pc  : fa;
    alu_b = id_ex.b_imm ? id_ex.imm : fb;

    case (id_ex.funct3)
      F3_BEQ:  br_taken = (fa == fb);
      F3_BNE:  br_taken = (fa != fb);
      F3_BLT:  br_taken = ($signed(fa) <  $signed(fb));
      F3_BGE:  br_taken = ($signed(fa) >= $signed(fb));
      F3_BLTU: br_taken = (fa <  fb);
      F3_BGEU: br_taken = (fa >= fb);
      default: br_taken = 1'b0;
    endcase

    flush  = id_ex.vld && ((id_ex.branch && br_taken) || id_ex.jal || id_ex.jalr);
    target = id_ex.jalr ? ((fa + id_ex.imm) & ~32'd1) : (id_ex.pc + id_ex.imm);

    ex_res            = '0;
    ex_res.reg_write  = id_ex.reg_write;
    ex_res.mem_read   = id_ex.mem_read;
    ex_res.mem_write  = id_ex.mem_write;
    ex_res.rd         = id_ex.rd;
    ex_res.store_data = fb;
    ex_res.result     = (id_ex.jal || id_ex.jalr) ? (id_ex.pc + 32'd4)
                                                  : alu_calc(id_ex.alu_op, alu_a, alu_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem <= ex_res;
      mem_wb <= '{reg_write: ex_mem.reg_write, mem_read: ex_mem.mem_read,
                  rd: ex_mem.rd, result: ex_mem.result, load_data: data_in};
      if (flush) begin
        pc    <= target;
        if_id <= '0;
        id_ex <= '0;
      end else if (stall) begin
        id_ex <= '0;
      end else begin
        pc    <= pc + 32'd4;
        if_id <= '{vld: 1'b1, pc: pc, instr: instruction};
        id_ex <= id_dec;
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed program bench: expected stores (cycle, address, data) go into a queue
// and a negedge monitor compares each DUT store; GPRs are checked hierarchically.
module tb_cpu;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_addr, instruction, data_addr, data_out, data_in;
  logic        mem_write, mem_read;

  cpu #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_addr  (instr_addr),
    .instruction (instruction),
    .data_addr   (data_addr),
    .data_out    (data_out),
    .data_in     (data_in),
    .mem_write   (mem_write),
    .mem_read    (mem_read)
  );

  always #5 clk = ~clk;

  logic [31:0] rom  [0:63];
  logic [31:0] dmem [0:63];

  assign instruction = (instr_addr[31:8] == 24'd0) ? rom[instr_addr[7:2]] : 32'h0000_0013;
  assign data_in     = dmem[data_addr[7:2]];

  always @(posedge clk) if (mem_write) dmem[data_addr[7:2]] <= data_out;

  int cyc;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  always @(negedge clk) begin
    st_t e;
    if (!rst && mem_write) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL store_unexpected: cyc %0d addr %h data %h, required no store", cyc, data_addr, data_out);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.addr != data_addr || e.data != data_out) begin
          n_miss++;
          $display("FAIL store: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                   cyc, data_addr, data_out, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] i_t(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                      logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] b_t(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] j_t(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Store cycles account for two load-use stalls and two taken-control flushes.
  task automatic push_run();
    exp_q.push_back('{cyc: 7,  addr: 32'd0,  data: 32'd10});
    exp_q.push_back('{cyc: 12, addr: 32'd4,  data: 32'd20});
    exp_q.push_back('{cyc: 16, addr: 32'd8,  data: 32'd10});
    exp_q.push_back('{cyc: 28, addr: 32'd12, data: 32'd72});
    exp_q.push_back('{cyc: 29, addr: 32'd16, data: 32'd30});
  endtask

  logic [31:0] exp_regs [0:17] = '{32'd0, 32'd5, 32'd10, 32'd15, 32'd10, 32'd10, 32'd15, 32'd20,
                                   32'd20, 32'd10, 32'd5, 32'd5, 32'd0, 32'd30, 32'd72, 32'd0,
                                   32'd3, 32'd72};
  logic [31:0] exp_mem [0:4] = '{32'd10, 32'd20, 32'd10, 32'd72, 32'd30};

  task automatic check_state();
    for (int i = 0; i < 18; i++) check($sformatf("x%0d", i), dut.registers.registers[i], exp_regs[i]);
    for (int i = 0; i < 5; i++) check($sformatf("mem[%0d]", i), dmem[i], exp_mem[i]);
    check("store_queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int nz;
    for (int i = 0; i < 64; i++) begin
      rom[i]  = 32'h0000_0013;
      dmem[i] = 32'd0;
    end
    rom[0]  = i_t(5, 0, F3_ADD, 1, OPC_OP_IMM);
    rom[1]  = i_t(10, 0, F3_ADD, 2, OPC_OP_IMM);
    rom[2]  = r_t(F7_BASE, 2, 1, F3_ADD, 3);
    rom[3]  = r_t(F7_ALT, 1, 3, F3_ADD, 4);
    rom[4]  = s_t(0, 2, 0);
    rom[5]  = i_t(0, 0, F3_WORD, 5, OPC_LOAD);
    rom[6]  = r_t(F7_BASE, 1, 5, F3_ADD, 6);
    rom[7]  = i_t(20, 0, F3_ADD, 7, OPC_OP_IMM);
    rom[8]  = s_t(4, 7, 0);
    rom[9]  = i_t(4, 0, F3_WORD, 8, OPC_LOAD);
    rom[10] = i_t(0, 0, F3_WORD, 9, OPC_LOAD);
    rom[11] = s_t(8, 9, 0);
    rom[12] = i_t(5, 0, F3_ADD, 10, OPC_OP_IMM);
    rom[13] = i_t(5, 0, F3_ADD, 11, OPC_OP_IMM);
    rom[14] = b_t(8, 11, 10, F3_BEQ);
    rom[15] = i_t(1, 0, F3_ADD, 12, OPC_OP_IMM);
    rom[16] = i_t(30, 0, F3_ADD, 13, OPC_OP_IMM);
    rom[17] = j_t(8, 14);
    rom[18] = i_t(1, 0, F3_ADD, 15, OPC_OP_IMM);
    rom[19] = i_t(3, 0, F3_ADD, 16, OPC_OP_IMM);
    rom[20] = i_t(0, 14, F3_ADD, 17, OPC_OP_IMM);
    rom[21] = s_t(12, 17, 0);
    rom[22] = s_t(16, 13, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_instr_addr", instr_addr, 32'd0);
    check("reset_mem_write", {31'b0, mem_write}, 32'd0);
    check("reset_mem_read", {31'b0, mem_read}, 32'd0);
    check("reset_data_addr", data_addr, 32'd0);
    check("reset_data_out", data_out, 32'd0);

    push_run();
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check_state();

    // Restart, then reset again while a store is still in flight.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{cyc: 7, addr: 32'd0, data: 32'd10});
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_instr_addr", instr_addr, 32'd0);
    check("midrun_reset_mem_write", {31'b0, mem_write}, 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.registers.registers[i] != 32'd0) nz++;
    check("midrun_reset_gprs_nonzero", nz, 32'd0);
    check("midrun_reset_store_queue", exp_q.size(), 32'd0);

    for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
    push_run();
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
